// File: rtl/dram_ctrl_pkg.sv
// Shared types and default parameters for the multiplexed-address RAM front-end controller.
package dram_ctrl_pkg;

    localparam int N_DEF            = 8;
    localparam int K_DEF            = 8;
    localparam int RD_LAT_DEF       = 1;
    localparam int REF_INTERVAL_DEF = 64;

    typedef enum logic [2:0] {
        IDLE,
        RAS,
        RAS_REL,
        CAS,
        CAS_REL,
        RD_WAIT,
        REF_RAS,
        REF_REL
    } state_e;

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh timer: raises ref_pending every REF_INTERVAL clocks and
// tracks the row to refresh next; ref_ack retires one refresh.
module dram_refresh_timer
    import dram_ctrl_pkg::*;
#(
    parameter int K            = K_DEF,
    parameter int REF_INTERVAL = REF_INTERVAL_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ref_ack,
    output logic         ref_pending,
    output logic [K-1:0] ref_row
);

    localparam int TW = $clog2(REF_INTERVAL);
    localparam logic [TW-1:0] RELOAD = TW'(REF_INTERVAL - 1);

    logic [TW-1:0] timer_q, timer_d;
    logic          pending_q, pending_d;
    logic [K-1:0]  row_q, row_d;

    // An expiry while a refresh is already pending is simply absorbed; expiry wins over ack.
    always_comb begin
        timer_d   = timer_q - 1'b1;
        pending_d = pending_q;
        row_d     = row_q;
        if (ref_ack) begin
            pending_d = 1'b0;
            row_d     = row_q + 1'b1;
        end
        if (timer_q == '0) begin
            timer_d   = RELOAD;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q   <= RELOAD;
            pending_q <= 1'b0;
            row_q     <= '0;
        end else begin
            timer_q   <= timer_d;
            pending_q <= pending_d;
            row_q     <= row_d;
        end
    end

    assign ref_pending = pending_q;
    assign ref_row     = row_q;

endmodule

// File: rtl/dram_ctrl.sv
// Request front-end for a RAS/CAS multiplexed-address RAM: sequences row/column
// strobes per access, returns a one-cycle response and interleaves RAS-only refresh.
module dram_ctrl
    import dram_ctrl_pkg::*;
#(
    parameter int N            = N_DEF,
    parameter int K            = K_DEF,
    parameter int RD_LAT       = RD_LAT_DEF,
    parameter int REF_INTERVAL = REF_INTERVAL_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_write,
    input  logic [2*K-1:0] req_addr,
    input  logic [N-1:0]   req_wdata,
    output logic           rsp_valid,
    output logic [N-1:0]   rsp_rdata,
    output logic           ram_enable,
    output logic [K-1:0]   ram_addr,
    output logic           ram_ras_b,
    output logic           ram_cas_b,
    output logic           ram_read,
    output logic [N-1:0]   ram_data_in,
    input  logic [N-1:0]   ram_data_out
);

    localparam int WW = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;

    state_e         state_q, state_d;
    logic [K-1:0]   col_q, col_d;
    logic [WW-1:0]  wait_q, wait_d;
    logic           enable_q, enable_d;
    logic [K-1:0]   addr_q, addr_d;
    logic           ras_b_q, ras_b_d;
    logic           cas_b_q, cas_b_d;
    logic           read_q, read_d;
    logic [N-1:0]   wdata_q, wdata_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [N-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic           ref_ack;
    logic           ref_pending;
    logic [K-1:0]   ref_row;

    dram_refresh_timer #(
        .K           (K),
        .REF_INTERVAL(REF_INTERVAL)
    ) u_refresh (
        .clk        (clk),
        .rst_n      (rst_n),
        .ref_ack    (ref_ack),
        .ref_pending(ref_pending),
        .ref_row    (ref_row)
    );

    assign req_ready = (state_q == IDLE) && !ref_pending;

    // Outputs are computed for the state being entered so every RAM pin is a flop.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        wait_d      = wait_q;
        enable_d    = 1'b1;
        addr_d      = addr_q;
        ras_b_d     = 1'b1;
        cas_b_d     = 1'b1;
        read_d      = read_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        ref_ack     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ref_pending) begin
                    state_d = REF_RAS;
                    addr_d  = ref_row;
                    ras_b_d = 1'b0;
                end else if (req_valid) begin
                    state_d = RAS;
                    addr_d  = req_addr[2*K-1:K];
                    col_d   = req_addr[K-1:0];
                    ras_b_d = 1'b0;
                    read_d  = !req_write;
                    wdata_d = req_wdata;
                end
            end
            RAS:     state_d = RAS_REL;
            RAS_REL: begin
                state_d = CAS;
                addr_d  = col_q;
                cas_b_d = 1'b0;
            end
            CAS:     state_d = CAS_REL;
            CAS_REL: begin
                if (!read_q || RD_LAT == 1) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    if (read_q) begin
                        rsp_rdata_d = ram_data_out;
                    end
                end else begin
                    state_d = RD_WAIT;
                    wait_d  = WW'(RD_LAT - 2);
                end
            end
            RD_WAIT: begin
                if (wait_q == '0) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = ram_data_out;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            REF_RAS: state_d = REF_REL;
            REF_REL: begin
                state_d = IDLE;
                ref_ack = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            wait_q      <= '0;
            enable_q    <= 1'b0;
            addr_q      <= '0;
            ras_b_q     <= 1'b1;
            cas_b_q     <= 1'b1;
            read_q      <= 1'b0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            wait_q      <= wait_d;
            enable_q    <= enable_d;
            addr_q      <= addr_d;
            ras_b_q     <= ras_b_d;
            cas_b_q     <= cas_b_d;
            read_q      <= read_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign ram_enable  = enable_q;
    assign ram_addr    = addr_q;
    assign ram_ras_b   = ras_b_q;
    assign ram_cas_b   = cas_b_q;
    assign ram_read    = read_q;
    assign ram_data_in = wdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_dram_ctrl.sv
// Bench for dram_ctrl: one instance at RD_LAT=1 and one at RD_LAT=3, each with a
// behavioural RAM, a refresh monitor and a shared response scoreboard.
module tb_dram_ctrl;

    localparam int REF_INT = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       req_valid, req_ready, req_write, rsp_valid;
    logic [1:0]       ram_enable, ram_ras_b, ram_cas_b, ram_read;
    logic [1:0][15:0] req_addr;
    logic [1:0][7:0]  req_wdata, rsp_rdata, ram_addr, ram_data_in, ram_data_out;
    logic [1:0]       active;
    logic [1:0][7:0]  last_rdata;
    logic [8:0]       sb [$];
    logic [7:0]       exp_mem [int];
    int               n_err = 0;
    int               n_checks = 0;
    int               cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int LAT = (g == 0) ? 1 : 3;

        dram_ctrl #(.N(8), .K(8), .RD_LAT(LAT), .REF_INTERVAL(REF_INT)) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .req_valid   (req_valid[g]),
            .req_ready   (req_ready[g]),
            .req_write   (req_write[g]),
            .req_addr    (req_addr[g]),
            .req_wdata   (req_wdata[g]),
            .rsp_valid   (rsp_valid[g]),
            .rsp_rdata   (rsp_rdata[g]),
            .ram_enable  (ram_enable[g]),
            .ram_addr    (ram_addr[g]),
            .ram_ras_b   (ram_ras_b[g]),
            .ram_cas_b   (ram_cas_b[g]),
            .ram_read    (ram_read[g]),
            .ram_data_in (ram_data_in[g]),
            .ram_data_out(ram_data_out[g])
        );

        // RAM model: row latched on RAS, data valid LAT cycles after CAS, poison otherwise.
        logic [7:0] mem [65536];
        logic [7:0] row_l;
        logic [7:0] pipe [LAT];
        always @(posedge clk) begin
            if (!ram_ras_b[g]) row_l <= ram_addr[g];
            if (!ram_cas_b[g] && !ram_read[g]) mem[{row_l, ram_addr[g]}] <= ram_data_in[g];
            pipe[0] <= (!ram_cas_b[g] && ram_read[g]) ? mem[{row_l, ram_addr[g]}] : 8'hEE;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign ram_data_out[g] = pipe[LAT-1];

        // Refresh and response monitor.
        int   ref_row_m = 0;
        int   last_ref = -1;
        logic touched = 1'b0;
        logic last_touched = 1'b0;
        logic prev_ref = 1'b0;
        logic saw_ff = 1'b0;
        logic wrapped = 1'b0;
        always @(negedge clk) begin
            if (!rst_n) begin
                ref_row_m = 0; last_ref = -1; touched = 1'b0; last_touched = 1'b0;
                prev_ref = 1'b0; saw_ff = 1'b0; wrapped = 1'b0;
            end else begin
                if (active[g]) touched = 1'b1;
                if (!ram_ras_b[g] || !ram_cas_b[g])
                    checkOutput("strobe_excl", 32'(ram_ras_b[g] | ram_cas_b[g]), 1);
                if (prev_ref) begin
                    checkOutput("ref_release", 32'({ram_ras_b[g], ram_cas_b[g]}), 3);
                    prev_ref = 1'b0;
                end
                if (!ram_ras_b[g] && !active[g]) begin
                    checkOutput("ref_row", 32'(ram_addr[g]), ref_row_m);
                    checkOutput("ref_cas", 32'(ram_cas_b[g]), 1);
                    if (last_ref >= 0 && !touched && !last_touched)
                        checkOutput("ref_interval", cyc - last_ref, REF_INT);
                    if (ref_row_m == 255) saw_ff = 1'b1;
                    else if (ref_row_m == 0 && saw_ff) wrapped = 1'b1;
                    ref_row_m = (ref_row_m + 1) % 256;
                    last_ref = cyc;
                    last_touched = touched;
                    touched = 1'b0;
                    prev_ref = 1'b1;
                end
                if (rsp_valid[g]) begin
                    checkOutput("rsp_expected", 32'(sb.size() > 0), 1);
                    if (sb.size() > 0) checkOutput("rsp_rdata", 32'({g == 1, rsp_rdata[g]}), 32'(sb.pop_front()));
                end
            end
        end
    end

    task automatic applyStimulus(input int d, input logic wr, input logic [15:0] addr, input logic [7:0] wd);
        int         waited = 0;
        int         last_cyc;
        logic [7:0] exp_rd;
        req_write[d] = wr; req_addr[d] = addr; req_wdata[d] = wd; req_valid[d] = 1'b1;
        while (!req_ready[d] && waited < 200) begin @(negedge clk); waited++; end
        checkOutput("handshake", 32'(req_ready[d]), 1);
        if (req_ready[d]) begin
            if (wr) begin
                exp_mem[d * 65536 + int'(addr)] = wd;
                exp_rd = last_rdata[d];
            end else begin
                exp_rd = exp_mem[d * 65536 + int'(addr)];
                last_rdata[d] = exp_rd;
            end
            sb.push_back({d[0], exp_rd});
            active[d] = 1'b1;
            last_cyc = wr ? 5 : 4 + ((d == 0) ? 1 : 3);
            @(posedge clk);
            #1 req_valid[d] = 1'b0;
            for (int c = 1; c <= last_cyc; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    checkOutput("c1_ras", 32'(ram_ras_b[d]), 0);
                    checkOutput("c1_cas", 32'(ram_cas_b[d]), 1);
                    checkOutput("c1_row", 32'(ram_addr[d]), 32'(addr[15:8]));
                    checkOutput("c1_read", 32'(ram_read[d]), 32'(!wr));
                    checkOutput("c1_wdata", 32'(ram_data_in[d]), 32'(wd));
                end else if (c == 2) begin
                    checkOutput("c2_ras", 32'(ram_ras_b[d]), 1);
                    checkOutput("c2_row", 32'(ram_addr[d]), 32'(addr[15:8]));
                end else if (c == 3) begin
                    checkOutput("c3_cas", 32'(ram_cas_b[d]), 0);
                    checkOutput("c3_ras", 32'(ram_ras_b[d]), 1);
                    checkOutput("c3_col", 32'(ram_addr[d]), 32'(addr[7:0]));
                end else begin
                    checkOutput("cN_strobes", 32'({ram_ras_b[d], ram_cas_b[d]}), 3);
                    checkOutput("cN_read", 32'(ram_read[d]), 32'(!wr));
                    checkOutput("cN_wdata", 32'(ram_data_in[d]), 32'(wd));
                end
                checkOutput("rsp_timing", 32'(rsp_valid[d]), 32'(c == last_cyc));
            end
            active[d] = 1'b0;
        end
        req_valid[d] = 1'b0;
    endtask

    initial begin
        int waited;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        active = '0; last_rdata = '0;
        rst_n = 1'b0;

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput("rst_enable", 32'(ram_enable[d]), 0);
            checkOutput("rst_strobes", 32'({ram_ras_b[d], ram_cas_b[d]}), 3);
            checkOutput("rst_rsp", 32'(rsp_valid[d]), 0);
            checkOutput("rst_ready", 32'(req_ready[d]), 1);
            checkOutput("rst_addr", 32'(ram_addr[d]), 0);
            checkOutput("rst_read", 32'(ram_read[d]), 0);
            checkOutput("rst_rdata", 32'(rsp_rdata[d]), 0);
            checkOutput("rst_wdata", 32'(ram_data_in[d]), 0);
        end
        rst_n = 1'b1;
        #1 checkOutput("enable_pre_edge", 32'(ram_enable), 0);
        @(negedge clk);
        checkOutput("enable_post_edge", 32'(ram_enable), 3);

        $display("[TB] write/read at RD_LAT=1");
        applyStimulus(0, 1'b1, 16'hA473, 8'hAA);
        applyStimulus(0, 1'b0, 16'hA473, 8'h00);
        applyStimulus(0, 1'b1, 16'h1B2C, 8'h3C);
        applyStimulus(0, 1'b0, 16'h1B2C, 8'h00);

        $display("[TB] request held across refresh");
        waited = 0;
        while (req_ready[0] && waited < 200) begin @(negedge clk); waited++; end
        checkOutput("ref_ready_drop", 32'(req_ready[0]), 0);
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 16'hA473; req_wdata[0] = 8'h00;
        @(negedge clk);
        checkOutput("ref_ras", 32'(ram_ras_b[0]), 0);
        checkOutput("ref_addr0", 32'(ram_addr[0]), 0);
        checkOutput("ref_nocas", 32'(ram_cas_b[0]), 1);
        checkOutput("ref_busy", 32'(req_ready[0]), 0);
        @(negedge clk);
        checkOutput("ref_rel", 32'(ram_ras_b[0]), 1);
        checkOutput("ref_rel_busy", 32'(req_ready[0]), 0);
        @(negedge clk);
        checkOutput("ref_done_ready", 32'(req_ready[0]), 1);
        applyStimulus(0, 1'b0, 16'hA473, 8'h00);
        waited = 0;
        while (ram_ras_b[0] && waited < 200) begin @(negedge clk); waited++; end
        checkOutput("ref_addr1", 32'(ram_addr[0]), 1);

        $display("[TB] RD_LAT=3 instance");
        applyStimulus(1, 1'b1, 16'hA473, 8'hAA);
        applyStimulus(1, 1'b0, 16'hA473, 8'h00);
        applyStimulus(1, 1'b1, 16'h00FF, 8'h5C);
        applyStimulus(1, 1'b0, 16'h00FF, 8'h00);

        $display("[TB] reset during CAS of a read");
        req_write[0] = 1'b0; req_addr[0] = 16'hA473; req_wdata[0] = 8'h00; req_valid[0] = 1'b1;
        waited = 0;
        while (!req_ready[0] && waited < 200) begin @(negedge clk); waited++; end
        active[0] = 1'b1;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("mid_cas_low", 32'(ram_cas_b[0]), 0);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_cas_high", 32'(ram_cas_b[0]), 1);
        checkOutput("rst_ras_high", 32'(ram_ras_b[0]), 1);
        checkOutput("rst_enable_low", 32'(ram_enable[0]), 0);
        sb.delete();
        last_rdata = '0;
        active[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("no_rsp_after_rst", 32'(rsp_valid[0]), 0);
        end
        applyStimulus(0, 1'b0, 16'hA473, 8'h00);

        $display("[TB] refresh row wrap");
        waited = 0;
        while (!gen_dut[0].wrapped && waited < 20000) begin @(negedge clk); waited++; end
        checkOutput("ref_wrap0", 32'(gen_dut[0].wrapped), 1);
        waited = 0;
        while (!gen_dut[1].wrapped && waited < 2000) begin @(negedge clk); waited++; end
        checkOutput("ref_wrap1", 32'(gen_dut[1].wrapped), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/dram_ctrl.md
Name: dram_ctrl

Overview:
- Front-end controller sitting directly upstream of the multiplexed-address RAM (ras_b/cas_b strobes, shared row/col address bus, enable, read).
- Accepts flat read/write requests on a valid/ready handshake and splits each address into row and column halves.
- Drives the RAS -> release -> CAS -> release strobe sequence, captures read data and returns a one-cycle response.
- Inserts periodic RAS-only refresh cycles from an internal timer.

Parameters:
- N, 8, data width.
- K, 8, row/column address width; the flat request address is 2K bits.
- RD_LAT, 1, cycles from the cas_b-low cycle to valid ram_data_out (>=1).
- REF_INTERVAL, 64, clocks between refresh requests (>=8).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  2K  {row, col}; row = [2K-1:K], col = [K-1:0].
- req_wdata  in  N  write data.
- rsp_valid  out  1  one-cycle completion pulse, for both reads and writes.
- rsp_rdata  out  N  read data; valid when rsp_valid is high for a read.
- ram_enable  out  1  RAM enable.
- ram_addr  out  K  multiplexed row/col address.
- ram_ras_b  out  1  row strobe, active-low.
- ram_cas_b  out  1  column strobe, active-low.
- ram_read  out  1  1 = read, 0 = write.
- ram_data_in  out  N  write data to the RAM.
- ram_data_out  in  N  read data from the RAM.

Behaviour:
- Reset values (async, rst_n=0):
  - ram_enable=0, ram_ras_b=1, ram_cas_b=1, ram_read=0, ram_addr=0, ram_data_in=0.
  - rsp_valid=0, rsp_rdata=0.
  - State IDLE, refresh row=0, ref_pending=0, refresh timer=REF_INTERVAL-1.
- ram_enable goes to 1 on the first rising edge after reset release and stays high.
- All RAM-side outputs and rsp_* are registered.
- req_ready = (state==IDLE) && !ref_pending; combinational from registered state. It is 1 right after reset.
- States: IDLE, RAS, RAS_REL, CAS, CAS_REL, RD_WAIT, REF_RAS, REF_REL.
- Access timing, with cycle 0 as the handshake cycle (req_valid && req_ready):
  - Request latches: row, col, write flag, wdata.
  - Cycle 1 (RAS): ram_addr=row, ras_b=0, ram_read=~write, ram_data_in=wdata.
  - Cycle 2 (RAS_REL): ras_b=1, ram_addr holds row.
  - Cycle 3 (CAS): ram_addr=col, cas_b=0.
  - Cycle 4 (CAS_REL): cas_b=1.
- Writes: rsp_valid=1 in cycle 5; rsp_rdata unchanged; IDLE in cycle 5.
- Reads:
  - ram_data_out is sampled on the edge ending cycle 3+RD_LAT.
  - rsp_valid=1 and rsp_rdata=sample in cycle 4+RD_LAT.
  - For RD_LAT>1, RD_WAIT holds after CAS_REL for RD_LAT-1 cycles.
  - IDLE is reached in the same cycle as rsp_valid.
- ram_read and ram_data_in hold their value from RAS until the next access begins.
- Back-to-back: a new handshake is legal in the rsp_valid cycle. Minimum period is 5 cycles at RD_LAT=1.
- Refresh timer:
  - Free-running down-counter; at 0 it sets ref_pending and reloads REF_INTERVAL-1.
  - A timer expiry while ref_pending is already set is dropped; there is no queueing.
- Refresh arbitration:
  - In IDLE, ref_pending beats req_valid, and req_ready is 0 while pending.
  - REF_RAS: ram_addr=refresh row, ras_b=0, cas_b=1.
  - REF_REL: ras_b=1; refresh row increments, wrapping 2^K-1 -> 0; ref_pending clears; next state IDLE.
  - If timer expiry and clear of ref_pending coincide, set wins.
- No rsp_valid is generated for refresh.
- A refresh never interrupts an access in flight; it waits for IDLE.
- Reset mid-operation: all outputs return to reset values immediately. The in-flight transaction is discarded and produces no rsp_valid.
- ras_b and cas_b are never low in the same cycle.

Decomposition:
- Shared package dram_ctrl_pkg holds:
  - The state enum (8 states above).
  - Defaults for N, K, RD_LAT, REF_INTERVAL.
- Sub-module dram_refresh_timer holds:
  - The down-counter, ref_pending flag and refresh row counter.
  - Inputs: clk, rst_n, ref_ack.
  - Outputs: ref_pending, ref_row.

Test Plan:
- Reset, hold rst_n=0 for 3 cycles -> all RAM strobes high, ram_enable=0, rsp_valid=0, req_ready=1. Next edge after release -> ram_enable=1.
- Write req_addr=16'hA473, wdata=8'hAA:
  - Cycle 1: ram_addr=A4, ras_b=0, read=0, data_in=AA.
  - Cycle 3: ram_addr=73, cas_b=0.
  - Cycle 5: rsp_valid pulse.
- Read req_addr=16'hA473, RAM model returning AA (RD_LAT=1):
  - Cycle 1: read=1.
  - Cycle 5: rsp_valid=1, rsp_rdata=8'hAA.
  - Repeat with RD_LAT=3 -> rsp at cycle 7.
- Hold req_valid across a timer expiry in IDLE:
  - req_ready drops.
  - REF_RAS with ram_addr=00, ras_b=0 for 1 cycle, no cas_b.
  - Request is accepted afterwards and the next refresh uses row 01.
- Force the refresh row to FF -> refresh drives ram_addr=FF, then the next refresh uses 00.
- Assert rst_n=0 during CAS of a read -> cas_b=1 immediately, no rsp_valid. After release, a new read of 16'hA473 completes normally.
